// File: rtl/acq_threshold_fsm_if.sv
// Dump/threshold/status bundle for one acquisition detector channel.
// The master side supplies the dumps and thresholds, and the slave side (the detector) reports status.
interface acq_threshold_fsm_if #(
  parameter int W = 20
);
  logic         dump_vld;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic [W-1:0] thresh;
  logic [W-1:0] thresh_lo;
  logic [W-1:0] integmag;
  logic         mag_vld;
  logic         acq;
  logic         acq_lock;
  logic [1:0]   state;
  logic         dwell_done;

  modport master (
    output dump_vld, ain, bin, thresh, thresh_lo,
    input  integmag, mag_vld, acq, acq_lock, state, dwell_done
  );

  modport slave (
    input  dump_vld, ain, bin, thresh, thresh_lo,
    output integmag, mag_vld, acq, acq_lock, state, dwell_done
  );
endinterface

// File: rtl/acq_threshold_fsm.sv
// Acquisition detector: |I|,|Q| -> max+min/2 envelope -> threshold hysteresis FSM.
// It also produces a dwell-timeout pulse, which the carrier search uses to step frequency bins.
//
// state    | meaning
// SEARCH   | no correlation yet; counting miss dumps toward dwell timeout
// VERIFY   | envelope above thresh; counting consecutive hits toward lock
// LOCK     | correlation confirmed
// LOSING   | locked, but envelope below thresh_lo; counting toward drop
module acq_threshold_fsm #(
  parameter int W       = 20,
  parameter int CONF_N  = 4,
  parameter int LOSS_M  = 4,
  parameter int DWELL_N = 10
) (
  input logic           mclk,
  input logic           res,
  acq_threshold_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCK   = 2'd2,
    S_LOSING = 2'd3
  } state_e;

  localparam logic [3:0] CONF_C  = 4'(CONF_N);
  localparam logic [3:0] LOSS_C  = 4'(LOSS_M);
  localparam logic [7:0] DWELL_C = 8'(DWELL_N);

  // Stage 1: magnitudes
  logic [W-1:0] abs_a_d, abs_b_d;
  logic [W-1:0] abs_a_q, abs_b_q;
  logic         s1_vld_q;

  // Stage 2: envelope
  logic [W-1:0] mx, mn;
  logic [W-1:0] mag_d;
  logic [W-1:0] integmag_q;
  logic         mag_vld_q;

  // Stage 3: FSM
  state_e     state_q, state_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic [7:0] dwell_cnt_q, dwell_cnt_d;
  logic       dwell_done_q, dwell_done_d;
  logic       acq_q, acq_lock_q;
  logic       hit, low;

  // The most negative input has no positive W-bit signed twin.
  // Read as unsigned, its two's complement gives exactly 2^(W-1), which is the magnitude we want.
  assign abs_a_d = bus.ain[W-1] ? (~bus.ain + W'(1)) : bus.ain;
  assign abs_b_d = bus.bin[W-1] ? (~bus.bin + W'(1)) : bus.bin;

  always_ff @(posedge mclk) begin
    if (res) begin
      abs_a_q  <= '0;
      abs_b_q  <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= bus.dump_vld;
      if (bus.dump_vld) begin
        abs_a_q <= abs_a_d;
        abs_b_q <= abs_b_d;
      end
    end
  end

  assign mx    = (abs_a_q >= abs_b_q) ? abs_a_q : abs_b_q;
  assign mn    = (abs_a_q >= abs_b_q) ? abs_b_q : abs_a_q;
  assign mag_d = mx + (mn >> 1);

  always_ff @(posedge mclk) begin
    if (res) begin
      integmag_q <= '0;
      mag_vld_q  <= 1'b0;
    end else begin
      mag_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        integmag_q <= mag_d;
      end
    end
  end

  assign hit = (integmag_q > bus.thresh);
  assign low = (integmag_q < bus.thresh_lo);

  always_comb begin
    state_d      = state_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    dwell_done_d = 1'b0;

    if (mag_vld_q) begin
      unique case (state_q)
        S_SEARCH: begin
          if (hit) begin
            dwell_cnt_d = '0;
            if (CONF_C == 4'd1) begin
              state_d   = S_LOCK;
              hit_cnt_d = '0;
            end else begin
              state_d   = S_VERIFY;
              hit_cnt_d = 4'd1;
            end
          end else if (dwell_cnt_q + 8'd1 == DWELL_C) begin
            dwell_done_d = 1'b1;
            dwell_cnt_d  = '0;
          end else begin
            dwell_cnt_d = dwell_cnt_q + 8'd1;
          end
        end

        S_VERIFY: begin
          if (!hit) begin
            state_d     = S_SEARCH;
            hit_cnt_d   = '0;
            miss_cnt_d  = '0;
            dwell_cnt_d = '0;
          end else if (hit_cnt_q + 4'd1 == CONF_C) begin
            state_d   = S_LOCK;
            hit_cnt_d = '0;
          end else begin
            hit_cnt_d = hit_cnt_q + 4'd1;
          end
        end

        S_LOCK: begin
          if (low) begin
            if (LOSS_C == 4'd1) begin
              state_d     = S_SEARCH;
              hit_cnt_d   = '0;
              miss_cnt_d  = '0;
              dwell_cnt_d = '0;
            end else begin
              state_d    = S_LOSING;
              miss_cnt_d = 4'd1;
            end
          end
        end

        S_LOSING: begin
          if (!low) begin
            state_d    = S_LOCK;
            miss_cnt_d = '0;
          end else if (miss_cnt_q + 4'd1 == LOSS_C) begin
            state_d     = S_SEARCH;
            hit_cnt_d   = '0;
            miss_cnt_d  = '0;
            dwell_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
          end
        end

        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (res) begin
      state_q      <= S_SEARCH;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      dwell_cnt_q  <= '0;
      dwell_done_q <= 1'b0;
      acq_q        <= 1'b0;
      acq_lock_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      dwell_done_q <= dwell_done_d;
      acq_q        <= (state_d != S_SEARCH);
      acq_lock_q   <= (state_d == S_LOCK) || (state_d == S_LOSING);
    end
  end

  assign bus.integmag   = integmag_q;
  assign bus.mag_vld    = mag_vld_q;
  assign bus.acq        = acq_q;
  assign bus.acq_lock   = acq_lock_q;
  assign bus.state      = state_q;
  assign bus.dwell_done = dwell_done_q;

endmodule

// File: tb/tb_acq_threshold_fsm.sv
// Directed bench for acq_threshold_fsm (W=20, CONF_N=4, LOSS_M=4, DWELL_N=10).
module tb_acq_threshold_fsm;

  logic mclk = 1'b0;
  logic res;
  int   total = 0;
  int   bad   = 0;

  acq_threshold_fsm_if #(.W(20)) bus ();

  acq_threshold_fsm #(
    .W(20), .CONF_N(4), .LOSS_M(4), .DWELL_N(10)
  ) dut (
    .mclk (mclk),
    .res  (res),
    .bus  (bus.slave)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Dump one pair; check the envelope in the mag_vld cycle, return once the FSM outputs are visible.
  task automatic send(input logic [19:0] a, input logic [19:0] b, input int exp_mag, input string tag);
    bus.ain      = a;
    bus.bin      = b;
    bus.dump_vld = 1'b1;
    tick();
    bus.dump_vld = 1'b0;
    tick();
    chk({tag, "_mag"}, 32'(bus.integmag), exp_mag);
    chk({tag, "_vld"}, 32'(bus.mag_vld), 1);
    tick();
  endtask

  task automatic do_reset();
    res          = 1'b1;
    bus.dump_vld = 1'b0;
    tick();
    res = 1'b0;
  endtask

  task automatic chk_fsm(input string tag, input int st, input int acq, input int lck);
    chk({tag, "_state"}, 32'(bus.state), st);
    chk({tag, "_acq"}, 32'(bus.acq), acq);
    chk({tag, "_lock"}, 32'(bus.acq_lock), lck);
  endtask

  initial begin
    // T1: reset held two cycles with dumps offered
    res           = 1'b1;
    bus.dump_vld  = 1'b1;
    bus.ain       = 20'd500;
    bus.bin       = 20'd0;
    bus.thresh    = 20'hFFFFF;
    bus.thresh_lo = 20'd0;
    tick();
    tick();
    chk("t1_mag", 32'(bus.integmag), 0);
    chk("t1_vld", 32'(bus.mag_vld), 0);
    chk_fsm("t1", 0, 0, 0);
    chk("t1_dwell", 32'(bus.dwell_done), 0);
    res          = 1'b0;
    bus.dump_vld = 1'b0;
    tick();
    chk("t1_vld_post1", 32'(bus.mag_vld), 0);
    tick();
    chk("t1_vld_post2", 32'(bus.mag_vld), 0);
    chk("t1_state_post", 32'(bus.state), 0);

    // T2: latency and envelope for -100/40
    bus.ain      = 20'(-100);
    bus.bin      = 20'd40;
    bus.dump_vld = 1'b1;
    tick();
    bus.dump_vld = 1'b0;
    chk("t2_vld_t1", 32'(bus.mag_vld), 0);
    tick();
    chk("t2_vld_t2", 32'(bus.mag_vld), 1);
    chk("t2_mag", 32'(bus.integmag), 120);
    tick();
    chk("t2_vld_t3", 32'(bus.mag_vld), 0);
    chk("t2_mag_hold", 32'(bus.integmag), 120);

    // T3: most negative inputs, no wrap
    send(20'h80000, 20'h80000, 786432, "t3");

    // Back-to-back dumps
    bus.ain = 20'd3; bus.bin = 20'd4; bus.dump_vld = 1'b1;
    tick();
    bus.ain = 20'(-7); bus.bin = 20'd10;
    tick();
    bus.dump_vld = 1'b0;
    chk("b2b_mag0", 32'(bus.integmag), 5);
    chk("b2b_vld0", 32'(bus.mag_vld), 1);
    tick();
    chk("b2b_mag1", 32'(bus.integmag), 13);
    chk("b2b_vld1", 32'(bus.mag_vld), 1);
    tick();
    chk("b2b_vld2", 32'(bus.mag_vld), 0);

    // T4: four hits to lock
    do_reset();
    bus.thresh    = 20'd1000;
    bus.thresh_lo = 20'd500;
    send(20'd1200, 20'd0, 1200, "t4_h1");
    chk_fsm("t4_h1", 1, 1, 0);
    send(20'd0, 20'(-1200), 1200, "t4_h2");
    chk_fsm("t4_h2", 1, 1, 0);
    send(20'd1200, 20'd0, 1200, "t4_h3");
    chk_fsm("t4_h3", 1, 1, 0);
    send(20'd1200, 20'd0, 1200, "t4_h4");
    chk_fsm("t4_h4", 2, 1, 1);

    // T4b: envelope equal to thresh is a miss
    do_reset();
    send(20'd1200, 20'd0, 1200, "t4b_h1");
    chk_fsm("t4b_h1", 1, 1, 0);
    send(20'd1000, 20'd0, 1000, "t4b_eq");
    chk_fsm("t4b_eq", 0, 0, 0);

    // T5: loss hysteresis
    do_reset();
    for (int i = 0; i < 4; i++) send(20'd1200, 20'd0, 1200, "t5_lk");
    chk_fsm("t5_lk", 2, 1, 1);
    send(20'd500, 20'd0, 500, "t5_eqlo");
    chk_fsm("t5_eqlo", 2, 1, 1);
    for (int i = 0; i < 3; i++) begin
      send(20'd400, 20'd0, 400, "t5_lo");
      chk_fsm("t5_lo", 3, 1, 1);
    end
    send(20'd600, 20'd0, 600, "t5_up");
    chk_fsm("t5_up", 2, 1, 1);
    send(20'd400, 20'd0, 400, "t5_d1");
    chk("t5_d1_state", 32'(bus.state), 3);
    send(20'd400, 20'd0, 400, "t5_d2");
    chk("t5_d2_state", 32'(bus.state), 3);
    send(20'd400, 20'd0, 400, "t5_d3");
    chk("t5_d3_state", 32'(bus.state), 3);
    send(20'd400, 20'd0, 400, "t5_d4");
    chk_fsm("t5_d4", 0, 0, 0);

    // T6: dwell timeout after ten misses
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      send(20'd0, 20'd0, 0, "t6_miss");
      chk("t6_dwell", 32'(bus.dwell_done), (i == 10) ? 1 : 0);
    end
    tick();
    chk("t6_dwell_end", 32'(bus.dwell_done), 0);
    chk("t6_state", 32'(bus.state), 0);

    // T6b: reset in VERIFY with a hit dump in flight
    send(20'd1200, 20'd0, 1200, "t6b_h1");
    chk_fsm("t6b_h1", 1, 1, 0);
    bus.ain      = 20'd1200;
    bus.bin      = 20'd0;
    bus.dump_vld = 1'b1;
    tick();
    bus.dump_vld = 1'b0;
    res          = 1'b1;
    tick();
    res = 1'b0;
    chk("t6b_vld_rst", 32'(bus.mag_vld), 0);
    chk_fsm("t6b_rst", 0, 0, 0);
    tick();
    chk("t6b_vld_post", 32'(bus.mag_vld), 0);
    tick();
    chk_fsm("t6b_post", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
